// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_sub_pkg;

    localparam int SS_WIDTH_DEF = 16;

    typedef enum logic [1:0] {
        SS_IDLE  = 2'd0,
        SS_SHIFT = 2'd1,
        SS_DONE  = 2'd2
    } ss_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = inA - inB - inBorrow.
// Pure combinational, zero latency, no flow control.
module full_subtractor (
    output logic diff,
    output logic borrowOut,
    input  logic inA,
    input  logic inB,
    input  logic inBorrow
);

    assign diff      = inA ^ inB ^ inBorrow;
    assign borrowOut = (~inA & inB) | (~(inA ^ inB) & inBorrow);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = inA - inB), one bit per clock, LSB first.
// Latency: done pulses WIDTH+1 cycles after the accept cycle; one op per WIDTH+2 cycles.
// Backpressure: start is taken only while ready; starts while busy/done are dropped.
// Optional flag outputs (zero/negative/overflow) are enabled by SERIAL_SUB_FLAGS_EN.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SS_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_FLAGS_EN
    output logic             zero,
    output logic             negative,
    output logic             overflow,
`endif
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    ss_state_t        state, state_n;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] reg_a, reg_b, diff_q;
    logic             brw_q;
    logic             d_bit, b_out;

    full_subtractor u_cell (
        .diff      (d_bit),
        .borrowOut (b_out),
        .inA       (reg_a[0]),
        .inB       (reg_b[0]),
        .inBorrow  (brw_q)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            SS_IDLE:  if (start) state_n = SS_SHIFT;
            SS_SHIFT: if (cnt == LAST) state_n = SS_DONE;
            SS_DONE:  state_n = SS_IDLE;
            default:  state_n = SS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= SS_IDLE;
            cnt    <= '0;
            reg_a  <= '0;
            reg_b  <= '0;
            diff_q <= '0;
            brw_q  <= 1'b0;
        end else begin
            state <= state_n;
            if (state == SS_IDLE && start) begin
                reg_a <= inA;
                reg_b <= inB;
                brw_q <= 1'b0;
                cnt   <= '0;
            end else if (state == SS_SHIFT) begin
                reg_a  <= reg_a >> 1;
                reg_b  <= reg_b >> 1;
                diff_q <= {d_bit, diff_q[WIDTH-1:1]};
                brw_q  <= b_out;
                cnt    <= cnt + 1'b1;
            end
        end
    end

`ifdef SERIAL_SUB_FLAGS_EN
    logic zero_q, neg_q, ovf_q;

    // On the last shift edge reg_a[0]/reg_b[0] hold the original operand MSBs.
    always_ff @(posedge clk) begin
        if (reset) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state == SS_SHIFT && cnt == LAST) begin
            zero_q <= ({d_bit, diff_q[WIDTH-1:1]} == '0);
            neg_q  <= d_bit;
            ovf_q  <= (reg_a[0] != reg_b[0]) && (d_bit != reg_a[0]);
        end
    end

    assign zero     = zero_q;
    assign negative = neg_q;
    assign overflow = ovf_q;
`endif

    assign ready  = (state == SS_IDLE);
    assign busy   = (state == SS_SHIFT);
    assign done   = (state == SS_DONE);
    assign diff   = diff_q;
    assign borrow = brw_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed/table-driven bench for serial_subtractor at WIDTH=16, plus a start-held stream vs a model.
module tb_serial_subtractor;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [W-1:0] inA, inB, diff;
    logic         ready, busy, done, borrow;
`ifdef SERIAL_SUB_FLAGS_EN
    logic         zero, negative, overflow;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .inA      (inA),
        .inB      (inB),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .diff     (diff),
`ifdef SERIAL_SUB_FLAGS_EN
        .zero     (zero),
        .negative (negative),
        .overflow (overflow),
`endif
        .borrow   (borrow)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_diff;
        logic         exp_borrow;
        logic         exp_zero;
        logic         exp_neg;
        logic         exp_ovf;
        int           pulse_at;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ready", ready, 1'b1);
    endtask

    // One operation from the negedge of the accept cycle; optionally pulses start
    // again with other operands in SHIFT cycle pulse_at, and scrambles inputs after accept.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int pulse_at,
                          output logic [W-1:0] d, output logic br, output int lat,
                          output int ndone);
        wait_ready();
        inA = a; inB = b; start = 1'b1;
        lat = -1; ndone = 0; d = 'x; br = 1'bx;
        @(negedge clk);
        start = 1'b0;
        inA = ~a; inB = a ^ b;
        for (int i = 1; i <= W + 5; i++) begin
            start = (i == pulse_at);
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = i; d = diff; br = borrow;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("hold_diff", diff, d);
    endtask

    vec_t         vecs[$];
    logic [W-1:0] got_d;
    logic         got_b;
    int           lat, ndone;
    logic [31:0]  q[$];
    logic [31:0]  ent;
    int           ops, cyc, last_done;

    initial begin
        vecs.push_back('{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 0});
        vecs.push_back('{16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b1, 1'b0, 0});
        vecs.push_back('{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 0});
        vecs.push_back('{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 5});
        vecs.push_back('{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 0});
        vecs.push_back('{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 0});
        vecs.push_back('{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b1, 1'b1, 0});
        vecs.push_back('{16'hA5A5, 16'h5A5A, 16'h4B4B, 1'b0, 1'b0, 1'b0, 1'b1, 0});

        reset = 1'b1; start = 1'b0; inA = '0; inB = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_diff", diff, 16'h0);
        chk("rst_borrow", borrow, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[k]) begin
            run_op(vecs[k].a, vecs[k].b, vecs[k].pulse_at, got_d, got_b, lat, ndone);
            chk($sformatf("v%0d_diff", k), got_d, vecs[k].exp_diff);
            chk($sformatf("v%0d_borrow", k), got_b, vecs[k].exp_borrow);
            chk($sformatf("v%0d_latency", k), lat, W + 1);
            chk($sformatf("v%0d_ndone", k), ndone, 1);
`ifdef SERIAL_SUB_FLAGS_EN
            chk($sformatf("v%0d_zero", k), zero, vecs[k].exp_zero);
            chk($sformatf("v%0d_neg", k), negative, vecs[k].exp_neg);
            chk($sformatf("v%0d_ovf", k), overflow, vecs[k].exp_ovf);
`endif
        end

        // Reset during the 8th SHIFT cycle aborts with no done pulse.
        wait_ready();
        inA = 16'hABCD; inB = 16'h1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_busy_before", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ready", ready, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_diff", diff, 16'h0);
        chk("abort_borrow", borrow, 1'b0);
        ndone = 0;
        for (int i = 0; i < W + 4; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("abort_no_done", ndone, 0);
        run_op(16'd7, 16'd2, 0, got_d, got_b, lat, ndone);
        chk("after_abort_diff", got_d, 16'd5);
        chk("after_abort_borrow", got_b, 1'b0);

        // Start held high: back-to-back ops against a reference model.
        wait_ready();
        inA = W'($urandom); inB = W'($urandom); start = 1'b1;
        ops = 0; cyc = 0; last_done = -1;
        while (ops < 1000 && cyc < 1000 * (W + 2) + 200) begin
            if (done) begin
                if (q.size() == 0) begin
                    chk("stream_queue_empty", 1'b1, 1'b0);
                end else begin
                    ent = q.pop_front();
                    chk("stream_diff", diff, W'(ent[31:16] - ent[15:0]));
                    chk("stream_borrow", borrow, ent[31:16] < ent[15:0]);
                end
                if (last_done >= 0) chk("stream_period", cyc - last_done, W + 2);
                last_done = cyc;
                ops++;
            end
            if (ready) q.push_back({inA, inB});
            else begin
                inA = W'($urandom);
                inB = W'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        chk("stream_ops", ops, 1000);
        start = 1'b0;
        repeat (W + 4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
